// File: rtl/regfile_param.sv
// Parametrised operand register file: 2^ADDR_W x DATA_W storage, one write port,
// two independent read ports, optional hardwired-zero register 0, optional
// write-to-read bypass, selectable read latency and a sequenced bulk-clear engine.
module regfile_param #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned ADDR_W       = 3,
  parameter bit          ZERO_REG     = 1'b1,
  parameter bit          BYPASS       = 1'b1,
  parameter int unsigned READ_LATENCY = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] reg_addr_1,
  input  logic [ADDR_W-1:0] reg_addr_2,
  output logic [DATA_W-1:0] reg_data_1,
  output logic [DATA_W-1:0] reg_data_2,
  input  logic              clear_req,
  output logic              clear_busy,
  output logic              write_dropped
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [0:0] {
    StIdle,
    StClear
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              write_dropped_q, write_dropped_d;

  logic              in_idle;
  logic              write_hit;
  logic              write_accept;
  logic [DATA_W-1:0] rd_v1, rd_v2;

  // A write is only honoured while the clear engine is idle.
  assign in_idle   = (state_q == StIdle);
  assign write_hit = write_enable && in_idle;
  // Writes to a hardwired-zero register 0 vanish silently (no dropped pulse).
  assign write_accept = write_hit && !(ZERO_REG && (write_addr == '0));

  // Clear sequencer: IDLE -> CLEAR on request, walk the pointer over every entry.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      StIdle: begin
        if (clear_req) begin
          state_d = StClear;
          ptr_d   = '0;
        end
      end
      StClear: begin
        // clear_req is ignored here; the sweep never restarts mid-way.
        ptr_d = ptr_q + 1'b1;
        if (&ptr_q) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        ptr_d   = '0;
      end
    endcase
  end

  // Storage next-state: accepted write and clear sweep never coincide.
  always_comb begin
    mem_d = mem_q;
    if (write_accept) begin
      mem_d[write_addr] = write_data;
    end
    if (state_q == StClear) begin
      mem_d[ptr_q] = '0;
    end
  end

  // A write attempted during the sweep is flagged on the following cycle.
  always_comb begin
    write_dropped_d = write_enable && (state_q == StClear);
  end

  // State, pointer, storage and dropped flag; async reset aborts any sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= StIdle;
      ptr_q           <= '0;
      write_dropped_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q         <= state_d;
      ptr_q           <= ptr_d;
      write_dropped_q <= write_dropped_d;
      mem_q           <= mem_d;
    end
  end

  assign clear_busy    = (state_q == StClear);
  assign write_dropped = write_dropped_q;

  // Read value per port: zero register wins, then bypass, then storage.
  always_comb begin
    rd_v1 = mem_q[reg_addr_1];
    if (BYPASS && write_hit && (reg_addr_1 == write_addr)) begin
      rd_v1 = write_data;
    end
    if (ZERO_REG && (reg_addr_1 == '0)) begin
      rd_v1 = '0;
    end

    rd_v2 = mem_q[reg_addr_2];
    if (BYPASS && write_hit && (reg_addr_2 == write_addr)) begin
      rd_v2 = write_data;
    end
    if (ZERO_REG && (reg_addr_2 == '0)) begin
      rd_v2 = '0;
    end
  end

  if (READ_LATENCY == 0) begin : g_comb_rd
    assign reg_data_1 = rd_v1;
    assign reg_data_2 = rd_v2;
  end else begin : g_reg_rd
    logic [DATA_W-1:0] rd1_q, rd2_q;

    // Registered read ports: one cycle of latency after the sampling edge.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd1_q <= '0;
        rd2_q <= '0;
      end else begin
        rd1_q <= rd_v1;
        rd2_q <= rd_v2;
      end
    end

    assign reg_data_1 = rd1_q;
    assign reg_data_2 = rd2_q;
  end

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: several configurations side by side,
// table-driven write/read vectors plus hand sequences for bypass, latency and clear.
module tb_regfile_param;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Shared stimulus for the 8x8 instances.
  logic       we, creq;
  logic [2:0] wa, ra1, ra2;
  logic [7:0] wd;
  logic [7:0] d1_a, d2_a, d1_n, d2_n, d1_l, d2_l;
  logic       busy_a, drop_a, busy_n, drop_n, busy_l, drop_l;

  // Stimulus for the 16x16 clear instance.
  logic        bwe, bcreq;
  logic [3:0]  bwa, bra1, bra2;
  logic [15:0] bwd, bd1, bd2;
  logic        bbusy, bdrop;

  // Defaults: ZERO_REG=1, BYPASS=1, READ_LATENCY=0.
  regfile_param u_dut (
    .clk(clk), .rst(rst), .write_enable(we), .write_addr(wa), .write_data(wd),
    .reg_addr_1(ra1), .reg_addr_2(ra2), .reg_data_1(d1_a), .reg_data_2(d2_a),
    .clear_req(creq), .clear_busy(busy_a), .write_dropped(drop_a)
  );

  regfile_param #(.ZERO_REG(1'b0), .BYPASS(1'b0)) u_nz (
    .clk(clk), .rst(rst), .write_enable(we), .write_addr(wa), .write_data(wd),
    .reg_addr_1(ra1), .reg_addr_2(ra2), .reg_data_1(d1_n), .reg_data_2(d2_n),
    .clear_req(creq), .clear_busy(busy_n), .write_dropped(drop_n)
  );

  regfile_param #(.READ_LATENCY(1)) u_lat (
    .clk(clk), .rst(rst), .write_enable(we), .write_addr(wa), .write_data(wd),
    .reg_addr_1(ra1), .reg_addr_2(ra2), .reg_data_1(d1_l), .reg_data_2(d2_l),
    .clear_req(creq), .clear_busy(busy_l), .write_dropped(drop_l)
  );

  regfile_param #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1'b0)) u_big (
    .clk(clk), .rst(rst), .write_enable(bwe), .write_addr(bwa), .write_data(bwd),
    .reg_addr_1(bra1), .reg_addr_2(bra2), .reg_data_1(bd1), .reg_data_2(bd2),
    .clear_req(bcreq), .clear_busy(bbusy), .write_dropped(bdrop)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: expectations queued at drive time, consumed at sample time.
  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  task automatic push(input string name, input logic [31:0] exp);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] act);
    sb_t e;
    if (sb_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL sb_underflow: got %0h, expected an entry queued", act);
    end else begin
      e = sb_q.pop_front();
      chk(e.name, act, e.exp);
    end
  endtask

  typedef struct {
    logic       we;
    logic [2:0] wa;
    logic [7:0] wd;
    logic [2:0] ra1, ra2;
    logic [7:0] e1, e2;    // ZERO_REG=1 instances
    logic [7:0] e1n, e2n;  // ZERO_REG=0 instance
  } vec_t;
  vec_t vecs[7];

  task automatic fill_big();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bwe = 1'b1;
      bwa = 4'(i);
      bwd = 16'((i << 12) | 16'h0101);
    end
    @(negedge clk);
    bwe = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int cnt;

    vecs[0] = '{1'b1, 3'd1, 8'hAA, 3'd1, 3'd2, 8'hAA, 8'h00, 8'hAA, 8'h00};
    vecs[1] = '{1'b1, 3'd2, 8'hBB, 3'd1, 3'd2, 8'hAA, 8'hBB, 8'hAA, 8'hBB};
    vecs[2] = '{1'b1, 3'd7, 8'h11, 3'd7, 3'd0, 8'h11, 8'h00, 8'h11, 8'h00};
    vecs[3] = '{1'b1, 3'd0, 8'hFF, 3'd0, 3'd1, 8'h00, 8'hAA, 8'hFF, 8'hAA};
    vecs[4] = '{1'b1, 3'd4, 8'hDD, 3'd4, 3'd4, 8'hDD, 8'hDD, 8'hDD, 8'hDD};
    vecs[5] = '{1'b0, 3'd4, 8'hFF, 3'd4, 3'd2, 8'hDD, 8'hBB, 8'hDD, 8'hBB};
    vecs[6] = '{1'b1, 3'd5, 8'h3C, 3'd5, 3'd3, 8'h3C, 8'h00, 8'h3C, 8'h00};

    rst = 1'b1;
    we = 1'b0; creq = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;
    bwe = 1'b0; bcreq = 1'b0; bwa = '0; bwd = '0; bra1 = '0; bra2 = '0;

    // Reset state.
    #12;
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_drop", 32'(drop_a), 0);
    chk("rst_lat_d1", 32'(d1_l), 0);
    chk("rst_lat_d2", 32'(d2_l), 0);
    chk("rst_big_busy", 32'(bbusy), 0);
    @(negedge clk);
    rst = 1'b0;

    // Every address pair reads zero after reset.
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        @(negedge clk);
        ra1 = 3'(i);
        ra2 = 3'(j);
        #1;
        chk($sformatf("zero_a_%0d_%0d", i, j), {32'(d1_a), 32'(d2_a)} == 64'd0 ? 0 : 1, 0);
        chk($sformatf("zero_n_%0d_%0d", i, j), {32'(d1_n), 32'(d2_n)} == 64'd0 ? 0 : 1, 0);
      end
    end

    // Table: write on one edge, read back with write_enable low.
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      we  = vecs[k].we;
      wa  = vecs[k].wa;
      wd  = vecs[k].wd;
      ra1 = vecs[k].ra1;
      ra2 = vecs[k].ra2;
      push($sformatf("v%0d_d1", k), 32'(vecs[k].e1));
      push($sformatf("v%0d_d2", k), 32'(vecs[k].e2));
      push($sformatf("v%0d_nz_d1", k), 32'(vecs[k].e1n));
      push($sformatf("v%0d_nz_d2", k), 32'(vecs[k].e2n));
      push($sformatf("v%0d_lat_d1", k), 32'(vecs[k].e1));
      push($sformatf("v%0d_drop", k), 0);
      @(negedge clk);
      we = 1'b0;
      #1;
      pop_chk(32'(d1_a));
      pop_chk(32'(d2_a));
      pop_chk(32'(d1_n));
      pop_chk(32'(d2_n));
      pop_chk(32'(d1_l));
      pop_chk(32'(drop_a));
    end

    // Read latency 1: new address shows only after the next edge.
    @(negedge clk);
    ra1 = 3'd1;
    push("lat_hold", 32'h3C);
    push("comb_now", 32'hAA);
    #1;
    pop_chk(32'(d1_l));
    pop_chk(32'(d1_a));
    push("lat_new", 32'hAA);
    @(posedge clk);
    #1;
    pop_chk(32'(d1_l));

    // Bypass: write 0xCC to addr 3 while reading addr 3.
    @(negedge clk);
    we = 1'b1; wa = 3'd3; wd = 8'hCC; ra1 = 3'd3; ra2 = 3'd3;
    #1;
    chk("byp_comb", 32'(d1_a), 32'hCC);
    chk("nobyp_old", 32'(d1_n), 32'h00);
    chk("lat_pre_edge", 32'(d1_l), 32'hAA);
    @(posedge clk);
    #1;
    we = 1'b0;
    chk("nobyp_after", 32'(d1_n), 32'hCC);
    chk("lat_after", 32'(d1_l), 32'hCC);
    chk("byp_stored", 32'(d2_a), 32'hCC);

    // Clear coincident with a write of 0x5A to addr 6; a second request mid-sweep is ignored.
    @(negedge clk);
    we = 1'b1; wa = 3'd6; wd = 8'h5A; creq = 1'b1; ra1 = 3'd6; ra2 = 3'd1;
    @(posedge clk);
    #1;
    we = 1'b0;
    creq = 1'b0;
    chk("cc_busy", 32'(busy_a), 1);
    chk("cc_drop", 32'(drop_a), 0);
    chk("cc_written", 32'(d1_a), 32'h5A);
    cnt = 1;
    while (busy_a && cnt < 40) begin
      creq = (cnt == 3);
      @(posedge clk);
      #1;
      creq = 1'b0;
      if (busy_a) cnt++;
    end
    chk("cc_cycles", cnt, 8);
    chk("cc_addr6", 32'(d1_a), 0);
    chk("cc_addr1", 32'(d2_a), 0);

    // Bulk clear on the 16x16 instance.
    fill_big();
    #1;
    bra1 = 4'd9;
    bra2 = 4'd0;
    #1;
    chk("big_fill9", 32'(bd1), 32'h9101);
    chk("big_fill0", 32'(bd2), 32'h0101);
    @(negedge clk);
    bcreq = 1'b1;
    @(posedge clk);
    #1;
    bcreq = 1'b0;
    bra2 = 4'd1;
    cnt = 0;
    while (bbusy && cnt < 40) begin
      cnt++;
      bwe = (cnt == 3);
      bwa = 4'd9;
      bwd = 16'hBEEF;
      @(posedge clk);
      #1;
      bwe = 1'b0;
      if (cnt == 3) begin
        chk("big_drop_pulse", 32'(bdrop), 1);
        chk("big_not_stored", 32'(bd1), 32'h9101);
        chk("big_below_ptr", 32'(bd2), 0);
      end
      if (cnt == 4) chk("big_drop_end", 32'(bdrop), 0);
    end
    chk("big_busy_cycles", cnt, 16);
    for (int i = 0; i < 16; i++) begin
      bra1 = 4'(i);
      bra2 = 4'(15 - i);
      #1;
      chk($sformatf("big_clr_%0d", i), {32'(bd1), 32'(bd2)} == 64'd0 ? 0 : 1, 0);
    end

    // Reset at clear cycle 5 aborts the sweep.
    fill_big();
    @(negedge clk);
    bcreq = 1'b1;
    @(posedge clk);
    #1;
    bcreq = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
    end
    #1;
    chk("mid_busy_before", 32'(bbusy), 1);
    rst = 1'b1;
    #1;
    chk("mid_busy_after", 32'(bbusy), 0);
    chk("mid_drop_after", 32'(bdrop), 0);
    for (int i = 0; i < 16; i++) begin
      bra1 = 4'(i);
      bra2 = 4'(i);
      #1;
      chk($sformatf("mid_rst_%0d", i), {32'(bd1), 32'(bd2)} == 64'd0 ? 0 : 1, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", 32'(bbusy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised successor to the fixed 8x8 register bank: 2^ADDR_W registers of DATA_W bits, one write port and two read ports.
- Adds three features:
  - optional hardwired-zero register 0;
  - optional write-to-read bypass and selectable read latency (0 or 1);
  - a sequenced bulk-clear engine with busy/dropped-write signalling.
- Sits as the operand register file of the practice datapath.

Parameters:
- DATA_W, 8, register width in bits (>=1).
- ADDR_W, 3, address width; DEPTH = 2^ADDR_W registers.
- ZERO_REG, 1, 1: register 0 reads 0 and ignores writes; 0: register 0 is ordinary storage.
- BYPASS, 1, 1: a same-cycle write to an address being read is forwarded to that read port.
- READ_LATENCY, 0, 0: combinational reads; 1: read data registered on the clk rising edge.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- write_enable  input  1  write strobe.
- write_addr  input  ADDR_W  write address.
- write_data  input  DATA_W  write data.
- reg_addr_1  input  ADDR_W  read port 1 address.
- reg_addr_2  input  ADDR_W  read port 2 address.
- reg_data_1  output  DATA_W  read port 1 data.
- reg_data_2  output  DATA_W  read port 2 data.
- clear_req  input  1  one-cycle pulse that starts the bulk clear.
- clear_busy  output  1  high while the clear sequence runs.
- write_dropped  output  1  registered; one-cycle pulse when a write is rejected because of clear.

Behaviour:
- Reset (asynchronous, rst=1):
  - all registers 0, FSM in IDLE, clear pointer 0;
  - clear_busy=0, write_dropped=0, registered read outputs 0;
  - reads with READ_LATENCY=0 then return 0.
- Write:
  - on clk rising edge with write_enable=1 and FSM in IDLE, mem[write_addr] <= write_data;
  - if ZERO_REG=1 and write_addr=0, the write is silently ignored (write_dropped is not asserted).
- Read value v(addr):
  - 0 if ZERO_REG=1 and addr=0;
  - otherwise, write_data if BYPASS=1 and the write is accepted this cycle (write_enable=1, IDLE, addr=write_addr);
  - otherwise mem[addr].
- READ_LATENCY=0: reg_data_n = v(reg_addr_n) combinationally.
- READ_LATENCY=1: reg_data_n <= v(reg_addr_n) at each rising edge, giving 1-cycle latency. With BYPASS=0, a read of a just-written address shows the new value one cycle after the write edge.
- Both read ports are fully independent and may use the same address.
- Clear FSM has two states, IDLE and CLEAR:
  - IDLE -> CLEAR on a clk edge with clear_req=1; the pointer loads 0.
  - In CLEAR, each cycle: mem[ptr] <= 0, ptr <= ptr+1, wrapping modulo DEPTH.
  - CLEAR -> IDLE on the edge that clears ptr = DEPTH-1, so clear takes exactly DEPTH cycles.
  - clear_busy = (state==CLEAR), decoded from the state register.
  - clear_req while in CLEAR is ignored; it does not restart the sequence.
- Writes during CLEAR are not performed and are not bypassed. write_dropped is asserted the cycle after the edge on which write_enable=1 was seen in CLEAR.
- Simultaneous clear_req and write_enable in IDLE: the write is accepted on that edge; clearing starts on the same edge and wipes that register in turn.
- Reads during CLEAR return current storage: addresses below ptr read 0, the rest read old contents.
- Assertion of rst mid-clear aborts immediately to the reset state.
- No arithmetic other than the pointer increment; the pointer is ADDR_W bits wide and wraps naturally.

Test Plan:
- Defaults, after reset:
  - read every address pair -> all 0.
  - write 0xAA to 1, 0xBB to 2, 0x11 to 7 -> ra1=1/ra2=2 gives 0xAA/0xBB; ra1=7/ra2=0 gives 0x11/0x00.
- ZERO_REG:
  - ZERO_REG=1: write 0xFF to address 0 -> reads 0x00, write_dropped stays 0.
  - ZERO_REG=0: same write -> reads 0xFF.
- Bypass and latency, write 0xCC to addr 3 with ra1=3 in the same cycle:
  - BYPASS=1, READ_LATENCY=0 -> reg_data_1=0xCC before the edge.
  - BYPASS=0 -> old value before the edge, 0xCC after it.
  - READ_LATENCY=1 -> 0xCC appears one cycle after the sampling edge.
- Bulk clear, after filling all registers with non-zero data (DATA_W=16, ADDR_W=4):
  - pulse clear_req -> clear_busy high for exactly 16 cycles, then all reads 0.
  - write_enable during busy -> write_dropped pulses and the value is not stored.
- Reset and clear edge cases:
  - assert rst at clear cycle 5 -> busy drops at once, all reads 0.
  - clear_req coincident with a write of 0x5A to addr 6 -> addr 6 reads 0 after the clear completes.
- Write enable low:
  - write_enable=0 with write_addr=4, write_data=0xFF -> addr 4 keeps its previous 0xDD.
